serial_seq_tx: RTL

Serial sequence transmitter: accepts a parallel word over a valid/ready handshake and drives it onto a single-bit serial line, one bit per clock. Each word is framed by a fixed preamble and an idle gap. It is the driving end of the serial `x_in` stream consumed by the team's sequence-detector FSMs, and replaces `$random` stimulus with deterministic, framed traffic. It exposes its state register like the detector blocks do.

---
 rtl/serial_seq_tx.sv | 102 ++++++++++
 1 files changed

// File: rtl/serial_seq_tx.sv
// serial_seq_tx: framed serial word transmitter (preamble, data MSB first, idle gap).
// Define SERIAL_SEQ_TX_PARITY_EN to append an even-parity bit after the data bits.
module serial_seq_tx #(
    parameter int                 WIDTH   = 8,
    parameter int                 PRE_LEN = 4,
    parameter logic [PRE_LEN-1:0] PRE_PAT = 4'b1010,
    parameter int                 GAP_LEN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din_data,
    output logic             din_ready,
    output logic             x_out,
    output logic             x_en,
    output logic             done,
    output logic [1:0]       state
);
`ifdef SERIAL_SEQ_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int M1   = (PRE_LEN > WIDTH + 1) ? PRE_LEN : WIDTH + 1;
    localparam int MAXC = (M1 > GAP_LEN) ? M1 : GAP_LEN;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] PRE_LD  = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0] DATA_LD = CW'(WIDTH + PAR - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_LEN - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [1:0] {IDLE = 2'b00, PRE = 2'b01, DATA = 2'b10, GAP = 2'b11} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [PRE_LEN-1:0] pre_sh;
    logic               data_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

`ifdef SERIAL_SEQ_TX_PARITY_EN
    logic parity_q, parity_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_q <= 1'b0;
        else     parity_q <= parity_d;
    end
    always_comb parity_d = (state_q == IDLE && din_valid) ? ^din_data : parity_q;
    // The counter reaches zero on the extra cycle that follows the last data bit.
    assign data_bit = (cnt_q == '0) ? parity_q : shift_q[WIDTH-1];
`else
    assign data_bit = shift_q[WIDTH-1];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: if (din_valid) begin
                state_d = PRE;
                cnt_d   = PRE_LD;
                shift_d = din_data;
            end
            PRE: begin
                state_d = (cnt_q == '0) ? DATA : PRE;
                cnt_d   = (cnt_q == '0) ? DATA_LD : cnt_q - ONE;
            end
            DATA: begin
                shift_d = shift_q << 1;
                state_d = (cnt_q == '0) ? GAP : DATA;
                cnt_d   = (cnt_q == '0) ? GAP_LD : cnt_q - ONE;
            end
            GAP: begin
                state_d = (cnt_q == '0) ? IDLE : GAP;
                cnt_d   = (cnt_q == '0) ? '0 : cnt_q - ONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The preamble counts down from PRE_LEN-1, so it directly selects the next pattern bit.
    assign pre_sh = PRE_PAT >> cnt_q;

    always_comb begin
        din_ready = (state_q == IDLE);
        x_en      = (state_q == PRE) || (state_q == DATA);
        x_out     = (state_q == PRE) ? pre_sh[0] : (state_q == DATA) ? data_bit : 1'b0;
        done      = (state_q == GAP) && (cnt_q == '0);
        state     = state_q;
    end
endmodule
